fir_mac_multich: RTL and testbench
==================================

Name: fir_mac_multich

Overview:
- Parametrised multi-channel FIR multiply-accumulate engine; next generation of the single-channel 16-bit FIR core.
- On a start pulse it walks the coefficient address space once. It multiplies each returned coefficient against NUM_CH time-aligned samples in parallel and accumulates per channel.
- Results are rounded and saturated, then presented with a one-cycle done pulse.
- Sits between the coefficient ROM / sample delay-line queues and the downstream audio/sample path.

Parameters:
- DATA_W, 16, signed sample width (input and output)
- COEFF_W, 16, signed coefficient width
- NUM_COEFF, 1021, taps per filter pass (N)
- NUM_CH, 2, channels processed in parallel, sharing one coefficient stream
- FRAC_BITS, 15, fractional bits of the coefficient; result = accum >>> FRAC_BITS
- ACC_W, 42, accumulator width; must be >= DATA_W+COEFF_W+clog2(NUM_COEFF)
- ROUND, 1, 1 = round half-up before shift, 0 = truncate
- PTR_W, clog2(NUM_COEFF), address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a filter pass; sampled only in IDLE
- abort  in  1  synchronous cancel of the current pass
- cff_ptr  out  PTR_W  coefficient/sample address
- rd_en  out  1  address valid; memories return data exactly 1 cycle later
- cff_in  in  COEFF_W  signed coefficient for the previous cycle's cff_ptr
- smpl_in  in  NUM_CH*DATA_W  signed samples aligned with cff_in; channel c occupies bits [c*DATA_W +: DATA_W]
- smpl_out  out  NUM_CH*DATA_W  registered results, same packing
- sat  out  NUM_CH  per-channel saturation flag, registered with smpl_out
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when smpl_out/sat update

Behaviour:
- Reset values: state IDLE; cff_ptr 0; rd_en 0; all accumulators 0; smpl_out 0; sat 0; busy 0; done 0.
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE:
  - start=1 at an edge (E0) clears all accumulators and sets cff_ptr=0; next state FETCH.
  - start is ignored in every other state.
- FETCH:
  - rd_en=1; cff_ptr increments by 1 each cycle.
  - When cff_ptr==N-1, next state is DRAIN and cff_ptr returns to 0.
  - Addresses 0..N-1 are issued on N consecutive cycles.
- Data stage: a registered copy of rd_en qualifies cff_in/smpl_in. Every qualified cycle, acc[c] += cff_in * smpl_in[c] (full-precision signed product, sign-extended to ACC_W).
- DRAIN: rd_en=0; the last product is accumulated at edge E(N+1). Next state OUT.
- OUT:
  - Per channel: r = (acc[c] + (ROUND ? 2^(FRAC_BITS-1) : 0)) >>> FRAC_BITS.
  - If r > 2^(DATA_W-1)-1 → 0x7FFF..., sat[c]=1. If r < -2^(DATA_W-1) → 0x800..., sat[c]=1. Otherwise the low DATA_W bits, sat[c]=0.
  - Registered at E(N+2) together with done=1; state → IDLE.
- Latency:
  - done is high in the cycle following edge E(N+2), exactly one cycle.
  - busy is high from E0 until E(N+2) (N+2 cycles).
  - smpl_out/sat hold until the next done.
- Back-to-back: start may be asserted in the done cycle; it is accepted since state is IDLE.
- Abort: abort=1 in FETCH/DRAIN/OUT → next state IDLE, rd_en=0, cff_ptr=0, no done, smpl_out/sat unchanged. Abort in IDLE has no effect. abort wins over start if both are high in IDLE (start ignored).
- Accumulator never overflows, guaranteed by the ACC_W rule; no internal saturation.
- Reset mid-pass: immediate return to reset values; no done.

Test Plan:
- N=4, all cff_in=0x4000, smpl_in both ch=0x2000, start pulse at E0 → rd_en high 4 cycles; done only in the cycle after E6; smpl_out={0x4000,0x4000}; sat=00; busy high 6 cycles.
- N=4, ch0 cff=0x7FFF smpl=0x7FFF, ch1 smpl=0x8000 → ch0=0x7FFF, ch1=0x8000, sat=11.
- ROUND=1, single nonzero tap cff=0x0001, smpl=0x4000 → smpl_out ch=0x0001. Same with ROUND=0 → 0x0000.
- start held high continuously for 3 passes → passes back-to-back every 7 cycles (done then immediate re-accept); start pulses during busy are ignored.
- abort asserted at 2nd FETCH cycle → busy low next cycle, no done, smpl_out retains previous result. Following start → correct result from cleared accumulators.
- rst_n low mid-FETCH → all outputs 0 asynchronously; a fresh start afterwards gives the correct result.

Source files
------------

// File: rtl/fir_mac_multich.sv
// Multi-channel FIR multiply-accumulate engine: one coefficient stream shared by NUM_CH
// sample lanes, with per-channel rounding and saturation of the final result.
module fir_mac_multich #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEFF_W   = 16,
    parameter int unsigned NUM_COEFF = 1021,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned ACC_W     = 42,
    parameter int unsigned ROUND     = 1,
    parameter int unsigned PTR_W     = $clog2(NUM_COEFF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [PTR_W-1:0]         cff_ptr,
    output logic                     rd_en,
    input  logic [COEFF_W-1:0]       cff_in,
    input  logic [NUM_CH*DATA_W-1:0] smpl_in,
    output logic [NUM_CH*DATA_W-1:0] smpl_out,
    output logic [NUM_CH-1:0]        sat,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PROD_W = COEFF_W + DATA_W;

    // Rounding and saturation are evaluated one bit wider than the accumulator so the
    // half-LSB addition can never wrap.
    localparam logic signed [ACC_W:0] RND_ADD =
        (ROUND != 0) ? ((ACC_W+1)'(1) << (FRAC_BITS - 1)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_e;

    state_e                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic                      rd_q;
    logic                      clear_acc;
    logic                      load_out;
    logic signed [ACC_W-1:0]   acc_q [NUM_CH];
    logic signed [PROD_W-1:0]  prod [NUM_CH];
    logic signed [ACC_W:0]     rnd [NUM_CH];
    logic signed [ACC_W:0]     shf [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]  res;
    logic [NUM_CH-1:0]         res_sat;
    logic [NUM_CH*DATA_W-1:0]  out_q;
    logic [NUM_CH-1:0]         sat_q;
    logic                      done_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clear_acc = 1'b0;
        load_out  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StFetch;
                    ptr_d     = '0;
                    clear_acc = 1'b1;
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else if (ptr_q == PTR_W'(NUM_COEFF - 1)) begin
                    state_d = StDrain;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            StDrain: begin
                state_d = abort ? StIdle : StOut;
            end
            StOut: begin
                state_d  = StIdle;
                load_out = !abort;
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_en;
            done_q  <= load_out;
            if (load_out) begin
                out_q <= res;
                sat_q <= res_sat;
            end
        end
    end

    always_comb begin
        res     = '0;
        res_sat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c] = $signed(cff_in) * $signed(smpl_in[c*DATA_W +: DATA_W]);
            rnd[c]  = {acc_q[c][ACC_W-1], acc_q[c]} + RND_ADD;
            shf[c]  = rnd[c] >>> FRAC_BITS;
            if (shf[c] > SAT_MAX) begin
                res[c*DATA_W +: DATA_W] = {1'b0, {(DATA_W - 1){1'b1}}};
                res_sat[c]              = 1'b1;
            end else if (shf[c] < SAT_MIN) begin
                res[c*DATA_W +: DATA_W] = {1'b1, {(DATA_W - 1){1'b0}}};
                res_sat[c]              = 1'b1;
            end else begin
                res[c*DATA_W +: DATA_W] = shf[c][DATA_W-1:0];
            end
        end
    end

    // Memory data lags the address by one cycle, so rd_q qualifies cff_in/smpl_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear_acc) begin
                    acc_q[c] <= '0;
                end else if (rd_q) begin
                    acc_q[c] <= acc_q[c] + {{(ACC_W - PROD_W){prod[c][PROD_W-1]}}, prod[c]};
                end
            end
        end
    end

    assign cff_ptr  = ptr_q;
    assign rd_en    = (state_q == StFetch);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign smpl_out = out_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_fir_mac_multich.sv
// Bench for fir_mac_multich: two instances (rounding on/off) share stimulus and a ROM model;
// results are checked against a plain-arithmetic dot-product reference.
module tb_fir_mac_multich;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int N  = 4;
    localparam int NC = 2;
    localparam int AW = 42;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic [PW-1:0] ptr_a, ptr_b;
    logic rd_a, rd_b, busy_a, busy_b, done_a, done_b;
    logic [CW-1:0] cff_in;
    logic [NC*DW-1:0] smpl_in, out_a, out_b;
    logic [NC-1:0] sat_a, sat_b;

    logic [CW-1:0] coeff [N];
    logic [DW-1:0] smem [NC][N];
    logic [NC*DW-1:0] exp_out [2];
    logic [NC-1:0] exp_sat [2];

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fir_mac_multich #(.DATA_W(DW), .COEFF_W(CW), .NUM_COEFF(N), .NUM_CH(NC), .FRAC_BITS(15),
                      .ACC_W(AW), .ROUND(1), .PTR_W(PW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cff_ptr(ptr_a),
        .rd_en(rd_a), .cff_in(cff_in), .smpl_in(smpl_in), .smpl_out(out_a), .sat(sat_a),
        .busy(busy_a), .done(done_a));

    fir_mac_multich #(.DATA_W(DW), .COEFF_W(CW), .NUM_COEFF(N), .NUM_CH(NC), .FRAC_BITS(15),
                      .ACC_W(AW), .ROUND(0), .PTR_W(PW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cff_ptr(ptr_b),
        .rd_en(rd_b), .cff_in(cff_in), .smpl_in(smpl_in), .smpl_out(out_b), .sat(sat_b),
        .busy(busy_b), .done(done_b));

    // ROM / delay-line model: data one cycle after the address, noise when not reading.
    always @(posedge clk) begin
        if (rd_a) begin
            cff_in <= coeff[ptr_a];
            for (int c = 0; c < NC; c++) smpl_in[c*DW +: DW] <= smem[c][ptr_a];
        end else begin
            cff_in  <= CW'($urandom());
            smpl_in <= (NC*DW)'({$urandom(), $urandom()});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact dot product, optional half-LSB add, arithmetic shift, clamp.
    task automatic compute_model();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NC; c++) begin
                longint acc = 0;
                longint rv;
                for (int t = 0; t < N; t++) begin
                    int cv = $signed(coeff[t]);
                    int sv = $signed(smem[c][t]);
                    acc += longint'(cv) * longint'(sv);
                end
                rv = (acc + ((r == 0) ? 64'sd16384 : 64'sd0)) >>> 15;
                if (rv > 32767) begin
                    exp_out[r][c*DW +: DW] = 16'h7FFF;
                    exp_sat[r][c] = 1'b1;
                end else if (rv < -32768) begin
                    exp_out[r][c*DW +: DW] = 16'h8000;
                    exp_sat[r][c] = 1'b1;
                end else begin
                    exp_out[r][c*DW +: DW] = DW'(rv);
                    exp_sat[r][c] = 1'b0;
                end
            end
        end
    endtask

    task automatic fill_random(input int shamt);
        for (int t = 0; t < N; t++) begin
            coeff[t] = CW'($signed(CW'($urandom())) >>> shamt);
            for (int c = 0; c < NC; c++) smem[c][t] = DW'($signed(DW'($urandom())) >>> shamt);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, " out_rnd"}, 64'(out_a), 64'(exp_out[0]));
        check({tag, " sat_rnd"}, 64'(sat_a), 64'(exp_sat[0]));
        check({tag, " out_trunc"}, 64'(out_b), 64'(exp_out[1]));
        check({tag, " sat_trunc"}, 64'(sat_b), 64'(exp_sat[1]));
    endtask

    task automatic run_pass(input string tag, input bit poke_start);
        int done_idx_a = -1;
        int done_idx_b = -1;
        int done_cnt = 0;
        int busy_cnt = 0;
        int rd_cnt = 0;
        bit ptr_ok = 1'b1;
        compute_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (rd_a) begin
                rd_cnt++;
                if (int'(ptr_a) != i) ptr_ok = 1'b0;
            end
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                if (done_idx_a < 0) done_idx_a = i;
            end
            if (done_b && done_idx_b < 0) done_idx_b = i;
            start = poke_start && (i == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, 64'(done_idx_a), 64'(N + 2));
        check({tag, " done_cycle_trunc"}, 64'(done_idx_b), 64'(N + 2));
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(N + 2));
        check({tag, " rd_cycles"}, 64'(rd_cnt), 64'(N));
        check({tag, " ptr_seq"}, 64'(ptr_ok), 64'd1);
        check_results(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int t = 0; t < N; t++) begin
            coeff[t] = '0;
            for (int c = 0; c < NC; c++) smem[c][t] = '0;
        end
        #12;
        check("reset_outputs", 64'({ptr_a, rd_a, busy_a, done_a, out_a, sat_a}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Equal half-scale taps and quarter-scale samples give exactly 0x4000.
        for (int t = 0; t < N; t++) begin
            coeff[t] = 16'h4000;
            smem[0][t] = 16'h2000;
            smem[1][t] = 16'h2000;
        end
        run_pass("basic", 1'b1);
        check("basic_value", 64'(out_a), 64'h4000_4000);

        for (int t = 0; t < N; t++) begin
            coeff[t] = 16'h7FFF;
            smem[0][t] = 16'h7FFF;
            smem[1][t] = 16'h8000;
        end
        run_pass("saturate", 1'b0);
        check("saturate_flags", 64'(sat_a), 64'b11);

        for (int t = 0; t < N; t++) begin
            coeff[t] = (t == 0) ? 16'h0001 : 16'h0000;
            smem[0][t] = 16'h4000;
            smem[1][t] = 16'h4000;
        end
        run_pass("round_tap", 1'b0);
        check("round_half_up", 64'(out_a), 64'h0001_0001);
        check("truncate", 64'(out_b), 64'h0000_0000);

        // Held start: passes repeat every N+3 cycles.
        begin
            int dl[$];
            fill_random(3);
            compute_model();
            start = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < 30; i++) begin
                if (done_a) begin
                    dl.push_back(i);
                    if (dl.size() == 3) start = 1'b0;
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
            check("held_done_count", 64'(dl.size()), 64'd3);
            check("held_done0", 64'((dl.size() > 0) ? dl[0] : -1), 64'(N + 2));
            check("held_done1", 64'((dl.size() > 1) ? dl[1] : -1), 64'(2 * N + 5));
            check("held_done2", 64'((dl.size() > 2) ? dl[2] : -1), 64'(3 * N + 8));
            check("held_idle_after", 64'(busy_a), 64'd0);
            check_results("held");
        end

        // Abort on the second fetch cycle: results from the previous pass must survive.
        begin
            int dcnt = 0;
            fill_random(0);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check("abort_busy", 64'({busy_a, busy_b}), 64'd0);
            check("abort_rd_ptr", 64'({rd_a, ptr_a}), 64'd0);
            for (int i = 0; i < 10; i++) begin
                if (done_a || done_b) dcnt++;
                @(posedge clk); #1;
            end
            check("abort_no_done", 64'(dcnt), 64'd0);
            check_results("abort_hold");
        end
        run_pass("after_abort", 1'b0);

        // abort beats start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start", 64'({busy_a, rd_a}), 64'd0);

        // Asynchronous reset in the middle of a fetch.
        fill_random(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_a", 64'({ptr_a, rd_a, busy_a, done_a, out_a, sat_a}), 64'd0);
        check("midreset_b", 64'({ptr_b, rd_b, busy_b, done_b, out_b, sat_b}), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_pass("after_reset", 1'b0);

        for (int k = 0; k < 6; k++) begin
            fill_random((k % 3) * 2);
            run_pass($sformatf("random%0d", k), k[0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
